// File: rtl/gesture_toggle_generator_pkg.sv
// Types and constants shared by the swipe-gesture front-end and its bench.
`include "parameters.vh"

package gesture_toggle_generator_pkg;

  localparam int MODE_WIDTH = `MODE_WIDTH;
  localparam int MAX_WIDTH  = `MAX_WIDTH;
  localparam logic [MODE_WIDTH-1:0] OFF_MODE = `OFF_MODE;

  typedef enum logic [1:0] {
    IDLE         = `GESTURE_IDLE,
    WAIT_B       = `GESTURE_WAIT_B,
    WAIT_RELEASE = `GESTURE_WAIT_RELEASE
  } gesture_state_t;

  // A zero gap still gives B a window, so the load value is clamped to 1.
  function automatic logic [MAX_WIDTH-1:0] gap_load(input logic [MAX_WIDTH-1:0] gap);
    return (gap == '0) ? MAX_WIDTH'(1) : gap;
  endfunction

endpackage

// File: rtl/gesture_debouncer.sv
// One sensor channel: 2-flop synchroniser, stability counter and registered rising-edge event.
module gesture_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int DB_WIDTH        = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic evt
);

  logic                sync1_reg;
  logic                sync2_reg;
  logic                level_reg;
  logic                level_d_reg;
  logic                evt_reg;
  logic [DB_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      evt_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg   <= raw;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      evt_reg     <= level_reg & ~level_d_reg;
      // The sample that makes the count reach DEBOUNCE_CYCLES flips the level.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + DB_WIDTH'(1);
      end
    end
  end

  assign level = level_reg;
  assign evt   = evt_reg;

endmodule

// File: rtl/parameters.vh
// Shared hood-controller header: mode and gap-timer widths, OFF mode code, gesture FSM encodings.
`ifndef PARAMETERS_VH
`define PARAMETERS_VH
`define MODE_WIDTH 2
`define MAX_WIDTH 8
`define OFF_MODE 2'd0
`define GESTURE_IDLE 2'd0
`define GESTURE_WAIT_B 2'd1
`define GESTURE_WAIT_RELEASE 2'd2
`endif

// File: rtl/gesture_toggle_generator.sv
// Recognises an A-then-B swipe on the debounced IR sensors and emits the two-pulse toggle protocol.
module gesture_toggle_generator
  import gesture_toggle_generator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int DB_WIDTH        = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sensor_a_raw,
  input  logic                  sensor_b_raw,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic [MAX_WIDTH-1:0]  gap_time,
  output logic                  first_toggle_signal,
  output logic                  second_toggle_signal,
  output logic                  gesture_busy
);

  logic a_level, a_evt;
  logic b_level, b_evt;

  gesture_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_WIDTH(DB_WIDTH)) u_deb_a (
    .clk  (clk),
    .rstn (rstn),
    .raw  (sensor_a_raw),
    .level(a_level),
    .evt  (a_evt)
  );

  gesture_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_WIDTH(DB_WIDTH)) u_deb_b (
    .clk  (clk),
    .rstn (rstn),
    .raw  (sensor_b_raw),
    .level(b_level),
    .evt  (b_evt)
  );

  gesture_state_t       state_reg, state_next;
  logic [MAX_WIDTH-1:0] gap_cnt_reg, gap_cnt_next;
  logic                 first_reg, first_next;
  logic                 second_reg, second_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      first_reg   <= 1'b0;
      second_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      first_reg   <= first_next;
      second_reg  <= second_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    first_next   = 1'b0;
    second_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (a_evt && b_evt) begin
          state_next = WAIT_RELEASE;
        end else if (a_evt && current_mode != OFF_MODE) begin
          first_next   = 1'b1;
          gap_cnt_next = gap_load(gap_time);
          state_next   = WAIT_B;
        end
      end
      WAIT_B: begin
        // B wins over timeout so an event landing on the last window cycle still counts.
        if (current_mode == OFF_MODE) begin
          state_next = WAIT_RELEASE;
        end else if (b_evt) begin
          second_next = 1'b1;
          state_next  = WAIT_RELEASE;
        end else if (a_evt) begin
          first_next   = 1'b1;
          gap_cnt_next = gap_load(gap_time);
        end else if (gap_cnt_reg == '0) begin
          state_next = WAIT_RELEASE;
        end else begin
          gap_cnt_next = gap_cnt_reg - MAX_WIDTH'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!a_level && !b_level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign first_toggle_signal  = first_reg;
  assign second_toggle_signal = second_reg;
  assign gesture_busy         = (state_reg != IDLE);

endmodule

// File: doc/gesture_toggle_generator.md
Name: gesture_toggle_generator

Overview:
- Front-end for the hood's two IR proximity sensors: sensor A is the swipe start and sensor B is the swipe end.
- Synchronises and debounces both sensors, then recognises an A-then-B swipe.
- Emits the `first_toggle_signal` / `second_toggle_signal` pair consumed by the off-mode gesture controller.
- Sits between the sensor pads and the mode controllers, and produces the toggle protocol that the controller receives.

Parameters:
- DEBOUNCE_CYCLES, default 20: consecutive stable synchronised samples required before a debounced level changes. Valid range 1..65535.
- DB_WIDTH, default 16: width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous, active-low reset
- sensor_a_raw  input  1  asynchronous raw sensor A; high = hand present
- sensor_b_raw  input  1  asynchronous raw sensor B; high = hand present
- current_mode  input  `MODE_WIDTH  current hood mode
- gap_time  input  `MAX_WIDTH  max cycles allowed from A-event to B-event; sampled at the A-event
- first_toggle_signal  output  1  one-cycle pulse on an accepted A-event
- second_toggle_signal  output  1  one-cycle pulse on a B-event inside the window
- gesture_busy  output  1  high in every state except IDLE

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk.
  - All outputs are 0 in reset.
  - Synchroniser flops, debounced levels and counters are 0.
  - FSM is in IDLE.
- Input conditioning, per sensor:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are discarded.
  - Event = one-cycle rising edge of the debounced level (a_evt, b_evt).
- Latency: a raw rising edge stable from clk edge k gives a registered output pulse at edge k+DEBOUNCE_CYCLES+3.
- FSM states: IDLE, WAIT_B, WAIT_RELEASE.
- IDLE:
  - a_evt & !b_evt & current_mode != `OFF_MODE: pulse first_toggle_signal, load gap counter with max(gap_time,1), go to WAIT_B.
  - a_evt & b_evt in the same cycle (ambiguous): no pulse, go to WAIT_RELEASE.
  - b_evt alone: ignored.
  - a_evt in OFF_MODE: ignored, remain in IDLE.
- WAIT_B, priority order per cycle:
  1. current_mode == `OFF_MODE: abort, no pulse, go to WAIT_RELEASE.
  2. b_evt: pulse second_toggle_signal, go to WAIT_RELEASE. A b_evt in the same cycle the counter reaches 0 still counts.
  3. a_evt (re-entry): pulse first_toggle_signal again, reload counter, stay in WAIT_B.
  4. Counter == 0: timeout, no pulse, go to WAIT_RELEASE.
  5. Otherwise the counter decrements by 1; it never wraps below 0.
- WAIT_RELEASE: return to IDLE when both debounced levels are 0. Events in this state are ignored.
- Pulse spacing:
  - first_toggle_signal and second_toggle_signal are never high in the same cycle.
  - Each pulse is exactly one cycle.
  - second_toggle_signal rises at least 1 cycle after first_toggle_signal, which the receiver's edge detector requires.
- gap_time changes during WAIT_B have no effect until the next load.
- Reset mid-gesture: immediate return to IDLE, with outputs forced to 0 asynchronously.

Decomposition:
- Shared header parameters.vh holds `MODE_WIDTH, `MAX_WIDTH and `OFF_MODE (existing), plus new FSM encodings `GESTURE_IDLE, `GESTURE_WAIT_B and `GESTURE_WAIT_RELEASE (2 bits).
- Sub-module gesture_debouncer (synchroniser + debounce counter + rising-edge event, parameter DEBOUNCE_CYCLES), instantiated twice.
- Top level contains the FSM and the gap counter.

Test Plan (DEBOUNCE_CYCLES=4, gap_time=50, mode != OFF unless stated):
1. Clean swipe: A high at edge 10, B high at edge 30, both low at 60 -> first pulse at edge 17, second pulse at edge 37, gesture_busy low by edge ~67.
2. Timeout: A at 10, B at 90 -> first pulse at 17, no second pulse; FSM reaches WAIT_RELEASE at ~68.
3. Glitch reject: A high for 3 cycles, then B held high -> no pulses, FSM stays IDLE.
4. OFF_MODE:
   - A then B while current_mode=`OFF_MODE -> no pulses.
   - Mode switched to OFF during WAIT_B -> abort, B gives no second pulse.
5. Simultaneous A and B debounced in the same cycle -> no pulses; next clean swipe after release -> normal pulse pair.
6. Reset asserted mid-WAIT_B -> outputs 0 and IDLE immediately; after release, a full swipe works normally. Also: gap_time=0 with B in the next event cycle -> treated as a 1-cycle window.
